prbs_checker: RTL and testbench

//  Serial PRBS checker; sits directly downstream of the PRBS generator.

---
 rtl/prbs_pkg.sv | 15 +
 rtl/prbs_checker_if.sv | 33 +++
 rtl/prbs_sat_counter.sv | 24 ++
 rtl/prbs_checker.sv | 123 ++++++++++++
 tb/tb_prbs_checker.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and the default
// x^3+x^2+1 polynomial used by both generator and checker.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    localparam int PRBS3_ORDER = 3;
    localparam int PRBS3_TAP_A = 3;
    localparam int PRBS3_TAP_B = 2;

endpackage

// File: rtl/prbs_checker_if.sv
// Stream/status bundle between a PRBS source and prbs_checker.
// bit_cnt exists only when PRBS_CHK_BITCNT_EN is defined.
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             din_vld;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output din, din_vld, clr_cnt,
        input  locked, err_pulse, err_cnt, bit_cnt
    );
    modport slave (
        input  din, din_vld, clr_cnt,
        output locked, err_pulse, err_cnt, bit_cnt
    );
`else
    modport master (
        output din, din_vld, clr_cnt,
        input  locked, err_pulse, err_cnt
    );
    modport slave (
        input  din, din_vld, clr_cnt,
        output locked, err_pulse, err_cnt
    );
`endif
endinterface

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over inc.
module prbs_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with lock FSM and error counting.
// Define PRBS_CHK_BITCNT_EN to add a locked-bit counter (bit_cnt) for BER.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int ORDER       = PRBS3_ORDER,
    parameter int TAP_A       = PRBS3_TAP_A,
    parameter int TAP_B       = PRBS3_TAP_B,
    parameter int LOCK_THRESH = 8,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input logic          clk,
    input logic          rst_n,
    prbs_checker_if.slave bus
);
    localparam int MAX_AB = (ORDER > LOCK_THRESH) ? ORDER : LOCK_THRESH;
    localparam int MAX_C  = (MAX_AB > LOSS_THRESH) ? MAX_AB : LOSS_THRESH;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] FILL_LAST = CW'(ORDER - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_THRESH - 1);
    localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_THRESH - 1);

    prbs_state_e      r_state;
    logic [ORDER-1:0] r_hist;
    logic [CW-1:0]    r_cnt;
    logic             r_locked;
    logic             r_err_pulse;

    logic             w_pred;
    logic             w_miss;
    logic             w_err;
    logic [ORDER-1:0] w_sh_din;
    logic [ORDER-1:0] w_sh_pred;

    // r_hist[k-1] holds the bit seen k valid bits ago
    assign w_pred    = r_hist[TAP_A-1] ^ r_hist[TAP_B-1];
    assign w_miss    = bus.din ^ w_pred;
    assign w_sh_din  = {r_hist[ORDER-2:0], bus.din};
    assign w_sh_pred = {r_hist[ORDER-2:0], w_pred};
    assign w_err     = bus.din_vld && (r_state == ST_LOCKED) && w_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SEED;
            r_hist      <= '0;
            r_cnt       <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
            if (bus.din_vld) begin
                unique case (r_state)
                    ST_SEED: begin
                        r_hist <= w_sh_din;
                        if (r_cnt == FILL_LAST) begin
                            r_cnt <= '0;
                            if (|w_sh_din) r_state <= ST_VERIFY;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_VERIFY: begin
                        r_hist <= w_sh_din;
                        if (w_miss) begin
                            r_state <= ST_SEED;
                            r_cnt   <= '0;
                        end else if (r_cnt == LOCK_LAST) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // flywheel on the prediction so bad bits don't pollute history
                        r_hist <= w_sh_pred;
                        if (!w_miss) begin
                            r_cnt <= '0;
                        end else if (r_cnt == LOSS_LAST) begin
                            r_state  <= ST_SEED;
                            r_locked <= 1'b0;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= ST_SEED;
                        r_locked <= 1'b0;
                        r_cnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;

    prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_err),
        .i_clr (bus.clr_cnt),
        .o_cnt (bus.err_cnt)
    );

`ifdef PRBS_CHK_BITCNT_EN
    logic w_bit;
    assign w_bit = bus.din_vld && (r_state == ST_LOCKED);

    prbs_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_bit),
        .i_clr (bus.clr_cnt),
        .o_cnt (bus.bit_cnt)
    );
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: CNT_W=16 and CNT_W=4 instances
// driven by the same stream, checked against a bit-level reference model.
module tb_prbs_checker;
    localparam int ORD = 3;
    localparam int TA  = 3;
    localparam int TB  = 2;
    localparam int LT  = 8;
    localparam int LS  = 4;

    typedef struct {
        bit lk;
        bit ep;
        int ec;
        int bc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_W(16)) bus16 ();
    prbs_checker_if #(.CNT_W(4))  bus4 ();

    prbs_checker #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );
    prbs_checker #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, want, $time);
        end
    endtask

    // reference model: plain bit history, newest first
    int m_mode;
    int hist[$];
    int fill, run, miss, errs, bits;

    task automatic m_reset();
        m_mode = 0;
        hist = {};
        for (int i = 0; i < ORD; i++) hist.push_back(0);
        fill = 0; run = 0; miss = 0; errs = 0; bits = 0;
    endtask

    task automatic m_step(input bit d, input bit v, input bit c, output exp_t e);
        int p;
        int nz;
        e.ep = 0;
        if (v) begin
            p = hist[TA-1] ^ hist[TB-1];
            if (m_mode == 0) begin
                hist.push_front(d);
                void'(hist.pop_back());
                fill++;
                if (fill == ORD) begin
                    fill = 0;
                    nz = 0;
                    foreach (hist[i]) nz += hist[i];
                    if (nz != 0) begin m_mode = 1; run = 0; end
                end
            end else if (m_mode == 1) begin
                hist.push_front(d);
                void'(hist.pop_back());
                if (d != p) begin
                    m_mode = 0; fill = 0;
                end else begin
                    run++;
                    if (run == LT) begin m_mode = 2; miss = 0; end
                end
            end else begin
                hist.push_front(p);
                void'(hist.pop_back());
                bits++;
                if (d != p) begin
                    e.ep = 1;
                    errs++;
                    miss++;
                    if (miss == LS) begin m_mode = 0; fill = 0; end
                end else begin
                    miss = 0;
                end
            end
        end
        if (c) begin errs = 0; bits = 0; end
        e.lk = (m_mode == 2);
        e.ec = errs;
        e.bc = bits;
    endtask

    // stimulus source
    bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int pos = 0;

    task automatic step(input bit d, input bit v, input bit c);
        exp_t e;
        bus16.din = d; bus16.din_vld = v; bus16.clr_cnt = c;
        bus4.din = d;  bus4.din_vld = v;  bus4.clr_cnt = c;
        m_step(d, v, c, e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic send(input bit flip, input bit v, input bit c);
        bit d;
        d = pat[pos % 7] ^ flip;
        if (v) pos++;
        step(d, v, c);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("locked", int'(bus16.locked), int'(e.lk));
                chk("err_pulse", int'(bus16.err_pulse), int'(e.ep));
                chk("err_cnt", int'(bus16.err_cnt), (e.ec > 65535) ? 65535 : e.ec);
                chk("err_cnt4", int'(bus4.err_cnt), (e.ec > 15) ? 15 : e.ec);
`ifdef PRBS_CHK_BITCNT_EN
                chk("bit_cnt", int'(bus16.bit_cnt), (e.bc > 65535) ? 65535 : e.bc);
`endif
            end
        end
    end

    initial begin
        bus16.din = 0; bus16.din_vld = 0; bus16.clr_cnt = 0;
        bus4.din = 0;  bus4.din_vld = 0;  bus4.clr_cnt = 0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_locked", int'(bus16.locked), 0);
        chk("rst_cnt", int'(bus16.err_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // clean stream: lock after 11 bits, no errors
        for (int i = 0; i < 10; i++) send(0, 1, 0);
        chk("pre_lock", int'(bus16.locked), 0);
        send(0, 1, 0);
        chk("lock_11", int'(bus16.locked), 1);
        for (int i = 11; i < 200; i++) send(0, 1, 0);
        chk("clean_cnt", int'(bus16.err_cnt), 0);

        // single error
        send(1, 1, 0);
        for (int i = 0; i < 20; i++) send(0, 1, 0);
        chk("single_cnt", int'(bus16.err_cnt), 1);
        chk("single_lock", int'(bus16.locked), 1);

        // four consecutive errors drop lock, relock after 11
        for (int i = 0; i < 4; i++) send(1, 1, 0);
        chk("loss_lock", int'(bus16.locked), 0);
        chk("loss_cnt", int'(bus16.err_cnt), 5);
        for (int i = 0; i < 10; i++) send(0, 1, 0);
        chk("relock_10", int'(bus16.locked), 0);
        send(0, 1, 0);
        chk("relock_11", int'(bus16.locked), 1);

        // async reset mid-stream
        send(1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", int'(bus16.locked), 0);
        chk("arst_pulse", int'(bus16.err_pulse), 0);
        chk("arst_cnt", int'(bus16.err_cnt), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // stuck-at-0 never locks
        for (int i = 0; i < 100; i++) step(0, 1, 0);
        chk("stuck0_lock", int'(bus16.locked), 0);
        chk("stuck0_cnt", int'(bus16.err_cnt), 0);

        // din_vld toggling
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) send(0, i[0] == 1'b0, 0);
        chk("tog_lock", int'(bus16.locked), 1);
        send(0, 1, 0);
        send(1, 1, 1);
        chk("clr_pulse", int'(bus16.err_pulse), 1);
        chk("clr_cnt", int'(bus16.err_cnt), 0);

        // saturation of the 4-bit counter
        for (int k = 0; k < 20; k++) begin
            send(1, 1, 0);
            repeat (3) send(0, 1, 0);
        end
        chk("sat4", int'(bus4.err_cnt), 15);
        chk("sat16", int'(bus16.err_cnt), 20);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            send($urandom_range(15) == 0, $urandom_range(9) < 7,
                 $urandom_range(63) == 0);
        end
        step(0, 0, 0);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
